// File: rtl/lsu_mmio_pkg.sv
// Shared types for the load-store unit: load selector encoding,
// memory-map page numbers and a byte-lane merge helper.
package lsu_type;

    typedef enum logic [2:0] {
        LD_LB   = 3'b000,
        LD_LH   = 3'b001,
        LD_LW   = 3'b010,
        LD_LBU  = 3'b011,
        LD_LHU  = 3'b100,
        LD_NONE = 3'b111
    } ld_sel_e;

    localparam logic [19:0] DMEM_PAGE = 20'h00000;
    localparam logic [19:0] LEDR_PAGE = 20'h10000;
    localparam logic [19:0] LEDG_PAGE = 20'h10001;
    localparam logic [19:0] HEX_PAGE  = 20'h10002;
    localparam logic [19:0] SW_PAGE   = 20'h10010;

    // Replace only the bytes of old whose lane bit is set.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  lane
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = lane[i] ? data[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/lsu_mmio_if.sv
// Memory-stage request/response bundle between pipeline and LSU.
// master: pipeline side (drives requests); slave: the LSU.
interface lsu_mmio_if;

    logic [31:0] i_addr;
    logic [31:0] i_st_data;
    logic        i_wr_en;
    logic        i_rd_en;
    logic [3:0]  i_bmask;
    logic [2:0]  i_ld_sel;
    logic [31:0] o_ld_data;
    logic        o_ld_vld;
    logic        o_misaligned;

    modport master (
        output i_addr, i_st_data, i_wr_en, i_rd_en, i_bmask, i_ld_sel,
        input  o_ld_data, o_ld_vld, o_misaligned
    );

    modport slave (
        input  i_addr, i_st_data, i_wr_en, i_rd_en, i_bmask, i_ld_sel,
        output o_ld_data, o_ld_vld, o_misaligned
    );

endinterface

// File: rtl/lsu_mmio_dmem_bank.sv
// Four byte-lane synchronous RAMs sharing one word address.
// Ports: i_clk, i_addr (word), i_we (per lane), i_wdata, o_rdata (registered).
module dmem_bank #(
    parameter int AW = 9
) (
    input  logic          i_clk,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_we,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    localparam int DEPTH = 2 ** AW;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        // Read-before-write: a same-cycle read returns the old byte.
        always_ff @(posedge i_clk) begin
            if (i_we[l]) begin
                mem[i_addr] <= i_wdata[8*l +: 8];
            end
            rd_q <= mem[i_addr];
        end

        assign o_rdata[8*l +: 8] = rd_q;
    end

endmodule

// File: rtl/lsu_mmio.sv
// RV32I load-store unit: DMEM plus board I/O behind one memory map.
// Ports: i_clk, i_rst_n, bus (request/response), i_io_sw, o_io_ledr/ledg/hex.
module lsu_mmio
    import lsu_type::*;
#(
    parameter int DMEM_AW = 11
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    lsu_mmio_if.slave   bus,
    input  logic [31:0] i_io_sw,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [63:0] o_io_hex
);

    logic [19:0] page;
    logic [1:0]  off;
    logic        hit_dmem, hit_ledr, hit_ledg, hit_hex, hit_sw;
    logic        st_mis, ld_mis, st_go, ld_go;
    logic [3:0]  lane, dmem_we;
    logic [31:0] st_word, io_rd, dmem_rdata;
    ld_sel_e     ld_sel;
    logic        unused_addr;

    logic [31:0] ledr_d, ledr_q, ledg_d, ledg_q;
    logic [31:0] hex_lo_d, hex_lo_q, hex_hi_d, hex_hi_q;
    logic [31:0] sw1_q, sw2_q;
    logic        ld_vld_d, ld_vld_q, mis_d, mis_q;
    logic        ld_bad_d, ld_bad_q, ld_dmem_d, ld_dmem_q;
    logic [31:0] io_word_d, io_word_q;
    logic [1:0]  off_d, off_q;
    ld_sel_e     ld_sel_d, ld_sel_q;

    logic [31:0] word, shifted, ext;

    assign unused_addr = ^bus.i_addr[11:2];

    always_comb begin
        page     = bus.i_addr[31:12];
        off      = bus.i_addr[1:0];
        ld_sel   = ld_sel_e'(bus.i_ld_sel);
        hit_dmem = (page == DMEM_PAGE);
        hit_ledr = (page == LEDR_PAGE);
        hit_ledg = (page == LEDG_PAGE);
        hit_hex  = (page == HEX_PAGE);
        hit_sw   = (page == SW_PAGE);

        st_mis = ((bus.i_bmask == 4'b0011) && off[0])
              || ((bus.i_bmask == 4'b1111) && (off != 2'b00));
        ld_mis = (((ld_sel == LD_LH) || (ld_sel == LD_LHU)) && off[0])
              || ((ld_sel == LD_LW) && (off != 2'b00));

        // A store wins over a simultaneous load.
        st_go = bus.i_wr_en && !st_mis;
        ld_go = bus.i_rd_en && !bus.i_wr_en;

        lane    = bus.i_bmask << off;
        st_word = bus.i_st_data << {off, 3'b000};
        dmem_we = (st_go && hit_dmem) ? lane : 4'b0000;

        io_rd = 32'h0;
        unique case (1'b1)
            hit_ledr: io_rd = ledr_q;
            hit_ledg: io_rd = ledg_q;
            hit_hex:  io_rd = bus.i_addr[2] ? hex_hi_q : hex_lo_q;
            hit_sw:   io_rd = sw2_q;
            default:  io_rd = 32'h0;
        endcase

        ledr_d   = ledr_q;
        ledg_d   = ledg_q;
        hex_lo_d = hex_lo_q;
        hex_hi_d = hex_hi_q;
        if (st_go && hit_ledr) ledr_d = lane_merge(ledr_q, st_word, lane);
        if (st_go && hit_ledg) ledg_d = lane_merge(ledg_q, st_word, lane);
        if (st_go && hit_hex && !bus.i_addr[2]) begin
            hex_lo_d = lane_merge(hex_lo_q, st_word, lane);
        end
        if (st_go && hit_hex && bus.i_addr[2]) begin
            hex_hi_d = lane_merge(hex_hi_q, st_word, lane);
        end

        ld_vld_d  = ld_go;
        ld_bad_d  = ld_go && ld_mis;
        mis_d     = (bus.i_wr_en && st_mis) || (ld_go && ld_mis);
        ld_dmem_d = hit_dmem;
        io_word_d = io_rd;
        off_d     = off;
        ld_sel_d  = ld_sel;
    end

    dmem_bank #(
        .AW (DMEM_AW - 2)
    ) u_dmem (
        .i_clk   (i_clk),
        .i_addr  (bus.i_addr[DMEM_AW-1:2]),
        .i_we    (dmem_we),
        .i_wdata (st_word),
        .o_rdata (dmem_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ledr_q    <= '0;
            ledg_q    <= '0;
            hex_lo_q  <= '0;
            hex_hi_q  <= '0;
            sw1_q     <= '0;
            sw2_q     <= '0;
            ld_vld_q  <= 1'b0;
            ld_bad_q  <= 1'b0;
            mis_q     <= 1'b0;
            ld_dmem_q <= 1'b0;
            io_word_q <= '0;
            off_q     <= '0;
            ld_sel_q  <= LD_NONE;
        end else begin
            ledr_q    <= ledr_d;
            ledg_q    <= ledg_d;
            hex_lo_q  <= hex_lo_d;
            hex_hi_q  <= hex_hi_d;
            sw1_q     <= i_io_sw;
            sw2_q     <= sw1_q;
            ld_vld_q  <= ld_vld_d;
            ld_bad_q  <= ld_bad_d;
            mis_q     <= mis_d;
            ld_dmem_q <= ld_dmem_d;
            io_word_q <= io_word_d;
            off_q     <= off_d;
            ld_sel_q  <= ld_sel_d;
        end
    end

    always_comb begin
        word    = ld_dmem_q ? dmem_rdata : io_word_q;
        shifted = word >> {off_q, 3'b000};
        ext     = 32'h0;
        unique case (ld_sel_q)
            LD_LB:   ext = {{24{shifted[7]}}, shifted[7:0]};
            LD_LH:   ext = {{16{shifted[15]}}, shifted[15:0]};
            LD_LW:   ext = word;
            LD_LBU:  ext = {24'h0, shifted[7:0]};
            LD_LHU:  ext = {16'h0, shifted[15:0]};
            default: ext = 32'h0;
        endcase
    end

    assign bus.o_ld_data    = (ld_vld_q && !ld_bad_q) ? ext : 32'h0;
    assign bus.o_ld_vld     = ld_vld_q;
    assign bus.o_misaligned = mis_q;
    assign o_io_ledr        = ledr_q;
    assign o_io_ledg        = ledg_q;
    assign o_io_hex         = {hex_hi_q, hex_lo_q};

endmodule

// File: tb/tb_lsu_mmio.sv
// Directed bench for lsu_mmio with a byte-level reference model.
// Every cycle's outputs are compared against the model.
module tb_lsu_mmio;

    logic        clk;
    logic        rst_n;
    logic [31:0] sw;
    logic [31:0] ledr, ledg;
    logic [63:0] hex;

    lsu_mmio_if bus ();

    lsu_mmio #(
        .DMEM_AW (11)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .bus       (bus.slave),
        .i_io_sw   (sw),
        .o_io_ledr (ledr),
        .o_io_ledg (ledg),
        .o_io_hex  (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_fail;

    logic [7:0]  mem [2048];
    logic [31:0] m_ledr, m_ledg, m_s1, m_s2;
    logic [7:0]  m_hex [8];
    logic        exp_vld, exp_mis;
    logic [31:0] exp_data;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model_hex();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m_hex[i];
        return r;
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] a, input int k);
        int b;
        b = int'(a % 4) + k;
        case (a[31:12])
            20'h00000: return mem[(a + k) % 2048];
            20'h10000: return 8'(m_ledr >> (8 * b));
            20'h10001: return 8'(m_ledg >> (8 * b));
            20'h10002: return m_hex[(a[2] ? 4 : 0) + b];
            20'h10010: return 8'(m_s2 >> (8 * b));
            default:   return 8'h00;
        endcase
    endfunction

    task automatic wr_byte(input logic [31:0] a, input int k,
                           input logic [7:0] v);
        int b;
        b = int'(a % 4) + k;
        case (a[31:12])
            20'h00000: mem[(a + k) % 2048] = v;
            20'h10000: m_ledr[8*b +: 8] = v;
            20'h10001: m_ledg[8*b +: 8] = v;
            20'h10002: m_hex[(a[2] ? 4 : 0) + b] = v;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_ledr = 0;
        m_ledg = 0;
        m_s1 = 0;
        m_s2 = 0;
        for (int i = 0; i < 8; i++) m_hex[i] = 8'h00;
        exp_vld = 0;
        exp_mis = 0;
        exp_data = 0;
    endtask

    // Outcome of the coming clock edge, from the current inputs.
    task automatic model_eval();
        int sl, ss;
        logic [31:0] a, v;
        bit ld;
        a = bus.i_addr;
        ld = bus.i_rd_en && !bus.i_wr_en;
        case (bus.i_ld_sel)
            3'd0, 3'd3: sl = 1;
            3'd1, 3'd4: sl = 2;
            3'd2:       sl = 4;
            default:    sl = 0;
        endcase
        case (bus.i_bmask)
            4'b0001: ss = 1;
            4'b0011: ss = 2;
            4'b1111: ss = 4;
            default: ss = 0;
        endcase
        exp_vld = ld;
        exp_mis = 0;
        exp_data = 0;
        if (ld) begin
            if (sl > 1 && (a % sl) != 0) begin
                exp_mis = 1;
            end else if (sl > 0) begin
                v = 0;
                for (int k = 0; k < sl; k++) v = v | (32'(rd_byte(a, k)) << (8 * k));
                if (bus.i_ld_sel == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
                if (bus.i_ld_sel == 3'd1 && v[15]) v = v | 32'hFFFF0000;
                exp_data = v;
            end
        end
        if (bus.i_wr_en && ss > 0) begin
            if ((a % ss) != 0) exp_mis = 1;
            else for (int k = 0; k < ss; k++) wr_byte(a, k, 8'(bus.i_st_data >> (8 * k)));
        end
        m_s2 = m_s1;
        m_s1 = sw;
    endtask

    task automatic check_all();
        chk("ld_vld", 64'(bus.o_ld_vld), 64'(exp_vld));
        chk("misaligned", 64'(bus.o_misaligned), 64'(exp_mis));
        if (exp_vld) chk("ld_data", 64'(bus.o_ld_data), 64'(exp_data));
        chk("ledr", 64'(ledr), 64'(m_ledr));
        chk("ledg", 64'(ledg), 64'(m_ledg));
        chk("hex", hex, model_hex());
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        bus.i_wr_en = 0;
        bus.i_rd_en = 0;
        bus.i_bmask = 4'b0000;
        bus.i_ld_sel = 3'b111;
        bus.i_addr = 0;
        bus.i_st_data = 0;
    endtask

    task automatic st(input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] d);
        idle();
        bus.i_wr_en = 1;
        bus.i_addr = a;
        bus.i_bmask = m;
        bus.i_st_data = d;
        tick();
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] s);
        idle();
        bus.i_rd_en = 1;
        bus.i_addr = a;
        bus.i_ld_sel = s;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        sw = 0;
        idle();
        model_reset();
        rst_n = 0;
        #2;
        check_all();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1;

        st(32'h10, 4'b1111, 32'hDEADBEEF);
        ld(32'h13, 3'd0);
        chk("lb_lit", 64'(bus.o_ld_data), 64'hFFFFFFDE);
        idle();
        tick();
        chk("vld_one_cycle", 64'(bus.o_ld_vld), 64'h0);
        ld(32'h13, 3'd3);
        chk("lbu_lit", 64'(bus.o_ld_data), 64'h000000DE);
        ld(32'h12, 3'd4);
        chk("lhu_lit", 64'(bus.o_ld_data), 64'h0000DEAD);
        ld(32'h12, 3'd1);
        chk("lh_lit", 64'(bus.o_ld_data), 64'hFFFFDEAD);

        st(32'h12, 4'b0011, 32'h00001234);
        ld(32'h10, 3'd2);
        chk("lw_after_sh", 64'(bus.o_ld_data), 64'h1234BEEF);
        st(32'h10, 4'b0001, 32'h00000077);
        ld(32'h10, 3'd2);
        chk("lw_after_sb", 64'(bus.o_ld_data), 64'h1234BE77);

        st(32'h10000000, 4'b1111, 32'h0000A5A5);
        chk("ledr_lit", 64'(ledr), 64'h0000A5A5);
        st(32'h10002006, 4'b0001, 32'h0000003F);
        chk("hex_lit", hex, 64'h003F0000_00000000);
        st(32'h10002000, 4'b0011, 32'h0000BEEF);
        st(32'h10001002, 4'b0011, 32'h00005A5A);
        ld(32'h10001000, 3'd2);
        ld(32'h10002004, 3'd2);

        sw = 32'h00000F0F;
        idle();
        tick();
        ld(32'h10010000, 3'd2);
        chk("sw_1cyc_lit", 64'(bus.o_ld_data), 64'h0);
        ld(32'h10010000, 3'd2);
        chk("sw_2cyc_lit", 64'(bus.o_ld_data), 64'h00000F0F);

        ld(32'h11, 3'd2);
        chk("mis_ld_lit", 64'(bus.o_misaligned), 64'h1);
        chk("mis_ld_data", 64'(bus.o_ld_data), 64'h0);
        st(32'h12, 4'b1111, 32'hCAFEF00D);
        chk("mis_st_lit", 64'(bus.o_misaligned), 64'h1);
        ld(32'h10, 3'd2);
        chk("mis_st_nowr", 64'(bus.o_ld_data), 64'h1234BE77);
        st(32'h10010000, 4'b1111, 32'h12345678);
        ld(32'h10010000, 3'd2);
        chk("sw_ro", 64'(bus.o_ld_data), 64'h00000F0F);
        ld(32'h20000000, 3'd2);
        ld(32'h10, 3'd7);
        st(32'h40000000, 4'b1111, 32'hFFFFFFFF);

        idle();
        bus.i_wr_en = 1;
        bus.i_rd_en = 1;
        bus.i_bmask = 4'b1111;
        bus.i_ld_sel = 3'd2;
        bus.i_addr = 32'h20;
        bus.i_st_data = 32'h11111111;
        tick();
        chk("wr_rd_novld", 64'(bus.o_ld_vld), 64'h0);
        ld(32'h20, 3'd2);
        ld(32'h21, 3'd4);

        st(32'h10000000, 4'b1111, 32'h000000FF);
        idle();
        bus.i_rd_en = 1;
        bus.i_addr = 32'h10;
        bus.i_ld_sel = 3'd2;
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("rst_ledr_lit", 64'(ledr), 64'h0);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2 rst_n = 1;
        idle();
        tick();
        ld(32'h10, 3'd2);
        chk("dmem_kept", 64'(bus.o_ld_data), 64'h1234BE77);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
